uart_tx: RTL and testbench
==========================

# uart_tx

Byte-wide UART transmitter: accepts a byte on a single-cycle `trig` strobe and shifts it out on `tx` as 8N1 (one start bit, 8 data bits LSB first, one stop bit) at a rate set by a clock-divider parameter. It sits directly upstream of the on-chip logic analyzer capture. Its line output, start strobe, state register and bit index are exported as ports so the analyzer can probe them by name.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 234 (27 MHz / 115200): clock cycles per UART bit; legal range ≥ 2.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `trig`  in  1  start strobe; sampled only in IDLE.
- `data_i`  in  8  byte to send; captured on the accepting edge.
- `tx`  out  1  serial line, idle high; registered.
- `busy`  out  1  high while a frame is in progress (state ≠ IDLE); registered.
- `done`  out  1  one-cycle pulse marking the end of the stop bit.
- `present_state`  out  2  debug: current FSM state, encoding fixed by package.
- `data_ind`  out  3  debug: index of the data bit currently on `tx`.

## Operation

- States: IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11.
- Baud counter `cnt`, width $clog2(CLKS_PER_BIT), runs 0..CLKS_PER_BIT-1 in every non-IDLE state. It clears on each state or bit change.
- IDLE:
  - `tx`=1.
  - If `trig`=1, latch `data_i` into shift register, go to START with `cnt`=0.
- START:
  - `tx`=0.
  - At `cnt`=CLKS_PER_BIT-1, go to DATA with `data_ind`=0.
- DATA:
  - `tx`=latched bit[`data_ind`].
  - At `cnt`=CLKS_PER_BIT-1: if `data_ind`=7, go to STOP; else increment `data_ind`.
- STOP:
  - `tx`=1.
  - At `cnt`=CLKS_PER_BIT-1, go to IDLE and assert `done` for exactly one cycle.
- `trig` outside IDLE is ignored. `data_i` changes after acceptance do not affect the frame in flight.
- `data_ind` holds 0 outside DATA.
- Reset values: `tx`=1, `busy`=0, `done`=0, `present_state`=IDLE, `data_ind`=0, `cnt`=0, shift register=0.
- Reset mid-frame: all registers take reset values on the next edge, `tx` returns high, and no `done` pulse is produced.
- `rst` and `trig` asserted in the same cycle: reset wins and the byte is not accepted.

## Timing

- `trig` sampled at edge E0. From the cycle after E0, `tx`=0 and `busy`=1 (latency 1 cycle).
- Each bit lasts exactly CLKS_PER_BIT cycles. The frame spans 10·CLKS_PER_BIT cycles starting at E0+1.
- `done`=1 and `busy`=0 in cycle E0+10·CLKS_PER_BIT+1; `present_state` reads IDLE in that cycle.
- Back-to-back frames: a `trig` high in the `done` cycle is accepted. The next start bit then follows with no idle gap (the stop bit is exactly one bit long).
- All outputs come straight from flops; there is no combinational path from inputs to outputs.

## Structure

- Shared package `uart_pkg`:
  - `uart_state_t` enum with the fixed 2-bit encodings above, so analyzer probe decoding stays stable.
  - Constants `UART_DATA_BITS`=8 and `UART_DEFAULT_CLKS_PER_BIT`=234.
- One sub-module, `uart_baud_cnt`:
  - Parameterised counter with `clear` and `en` inputs.
  - Outputs `last`, asserted at `cnt`=CLKS_PER_BIT-1.
  - Reusable by a future `uart_rx`.
- Top level holds the FSM, shift register and `data_ind`.
- Elaboration check rejects CLKS_PER_BIT < 2.

## Test plan

All scenarios use CLKS_PER_BIT=4.

- Basic frame:
  - Stimulus: reset, then `trig`=1 with `data_i`=8'hA5 for one cycle.
  - Response: `tx` shows bits 0,1,0,1,0,0,1,0,1,1, each held for 4 cycles, beginning the cycle after the strobe.
  - `done` pulses once, 41 cycles after the accepting edge; `data_ind` steps 0..7.
- Extremes:
  - 8'h00: `tx` is low for 36 consecutive cycles, then high.
  - 8'hFF: `tx` is low for 4 cycles, then high for 36.
  - `present_state` sequence in both cases: 00→01→10→11→00.
- Trig while busy:
  - Stimulus: pulse `trig` with 8'h3C at cycle 10 of an 8'hA5 frame.
  - Response: the line output is identical to the basic frame and only one `done` pulse occurs.
- Back-to-back:
  - Stimulus: hold `trig`=1 through the `done` cycle with `data_i`=8'h81.
  - Response: the second start bit begins immediately after the first stop bit, and both frames decode correctly.
- Reset mid-frame:
  - Stimulus: assert `rst` for one cycle during DATA bit 3.
  - Response: next cycle `tx`=1, `busy`=0, `present_state`=00, `data_ind`=0; no `done` pulse.
  - A subsequent `trig` with 8'h5A sends a clean frame.
- Reset priority: `rst`=1 and `trig`=1 in the same cycle → no frame starts and `tx` stays high.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and constants for the tx path and a future rx.
package uart_pkg;
   typedef enum logic [1:0] {IDLE = 2'b00, START = 2'b01, DATA = 2'b10, STOP = 2'b11} uart_state_t;
   localparam int UART_DATA_BITS = 8;
   localparam int UART_DEFAULT_CLKS_PER_BIT = 234;
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake between a producer and the UART transmitter.
interface uart_tx_if;
   import uart_pkg::*;
   logic trig;
   logic [UART_DATA_BITS-1:0] data_i;
   logic busy;
   logic done;
   modport master (output trig, data_i, input busy, done);
   modport slave (input trig, data_i, output busy, done);
endinterface

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: wrapping bit-period counter, flags the last cycle of each bit.
module uart_baud_cnt import uart_pkg::*; #(
   parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic last
);
   localparam int W = $clog2(CLKS_PER_BIT);
   localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
   logic [W-1:0] cnt_q, cnt_d;
   assign last = cnt_q == LAST;
   always_comb cnt_d = (clear || (en && last)) ? '0 : en ? cnt_q + 1'b1 : cnt_q;
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 transmitter; every output is a flop so the logic analyzer probes stay glitch-free.
module uart_tx import uart_pkg::*; #(
   parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
   input  logic         clk,
   input  logic         rst,
   uart_tx_if.slave     bus,
   output logic         tx,
   output logic [1:0]   present_state,
   output logic [2:0]   data_ind
);
   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_START = START;
   localparam logic [1:0] S_DATA  = DATA;
   localparam logic [1:0] S_STOP  = STOP;
   localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);
   if (CLKS_PER_BIT < 2) begin : g_bad_div
      $error("uart_tx: CLKS_PER_BIT must be >= 2");
   end
   logic [1:0] st_q, st_d;
   logic [2:0] ind_q, ind_d;
   logic [UART_DATA_BITS-1:0] sh_q, sh_d;
   logic tx_q, tx_d, busy_q, busy_d, done_q, done_d;
   logic last;
   uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk   (clk),
      .rst   (rst),
      .clear (st_q == S_IDLE),
      .en    (st_q != S_IDLE),
      .last  (last)
   );
   // outputs are computed from next-state so tx/busy/done line up with present_state
   always_comb begin
      st_d = st_q == S_IDLE ? (bus.trig ? S_START : S_IDLE)
           : !last ? st_q
           : st_q == S_START ? S_DATA
           : st_q == S_DATA ? (ind_q == LAST_BIT ? S_STOP : S_DATA)
           : S_IDLE;
      ind_d  = (st_q == S_DATA && st_d == S_DATA) ? ind_q + 3'(last) : 3'd0;
      sh_d   = (st_q == S_IDLE && bus.trig) ? bus.data_i : sh_q;
      tx_d   = st_d == S_START ? 1'b0 : st_d == S_DATA ? sh_q[ind_d] : 1'b1;
      busy_d = st_d != S_IDLE;
      done_d = st_q == S_STOP && last;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q   <= S_IDLE;
         ind_q  <= '0;
         sh_q   <= '0;
         tx_q   <= 1'b1;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         st_q   <= st_d;
         ind_q  <= ind_d;
         sh_q   <= sh_d;
         tx_q   <= tx_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end
   assign tx            = tx_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign present_state = st_q;
   assign data_ind      = ind_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed frame vectors plus reset/back-to-back/busy-trig sequences at CLKS_PER_BIT=4.
module tb_uart_tx;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tx;
   logic [1:0] present_state;
   logic [2:0] data_ind;
   int pass = 0;
   int total = 0;
   uart_tx_if bus ();
   uart_tx #(.CLKS_PER_BIT(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus.slave),
      .tx            (tx),
      .present_state (present_state),
      .data_ind      (data_ind)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic [7:0] d;
      logic [9:0] f;
      string      n;
   } vec_t;
   vec_t vecs [3];
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) $display("FAIL %s: got %0h expected %0h", n, a, e);
      else pass++;
   endtask
   // accepting edge happens inside; returns in the first start-bit cycle
   task automatic strobe(input logic [7:0] d, input bit hold);
      bus.trig = 1'b1;
      bus.data_i = d;
      tick();
      bus.trig = hold;
      bus.data_i = ~d;
   endtask
   task automatic body(input string n, input logic [9:0] f, input bit inj);
      for (int c = 0; c < 40; c++) begin
         int b;
         b = c / 4;
         chk($sformatf("%s tx c%0d", n, c), 32'(tx), 32'(f[b]));
         chk($sformatf("%s busy c%0d", n, c), 32'(bus.busy), 1);
         chk($sformatf("%s done c%0d", n, c), 32'(bus.done), 0);
         chk($sformatf("%s state c%0d", n, c), 32'(present_state), b == 0 ? 1 : b == 9 ? 3 : 2);
         chk($sformatf("%s ind c%0d", n, c), 32'(data_ind), (b >= 1 && b <= 8) ? b - 1 : 0);
         if (inj && c == 9) begin
            bus.trig = 1'b1;
            bus.data_i = 8'h3C;
         end
         tick();
         if (inj && c == 9) bus.trig = 1'b0;
      end
   endtask
   task automatic done_cyc(input string n);
      chk({n, " done"}, 32'(bus.done), 1);
      chk({n, " done busy"}, 32'(bus.busy), 0);
      chk({n, " done state"}, 32'(present_state), 0);
      chk({n, " done tx"}, 32'(tx), 1);
      chk({n, " done ind"}, 32'(data_ind), 0);
   endtask
   task automatic idle_after(input string n, input int cycles);
      int dn, lo;
      dn = 0;
      lo = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         dn += int'(bus.done);
         lo += int'(!tx) + int'(bus.busy);
      end
      chk({n, " idle done pulses"}, dn, 0);
      chk({n, " idle line/busy active"}, lo, 0);
   endtask
   initial begin
      vecs[0] = '{8'hA5, 10'b1_1010_0101_0, "A5"};
      vecs[1] = '{8'h00, 10'b1_0000_0000_0, "00"};
      vecs[2] = '{8'hFF, 10'b1_1111_1111_0, "FF"};
      bus.trig = 1'b0;
      bus.data_i = 8'h00;
      tick();
      tick();
      chk("rst tx", 32'(tx), 1);
      chk("rst busy", 32'(bus.busy), 0);
      chk("rst done", 32'(bus.done), 0);
      chk("rst state", 32'(present_state), 0);
      chk("rst ind", 32'(data_ind), 0);
      rst = 1'b0;
      tick();
      for (int v = 0; v < 3; v++) begin
         strobe(vecs[v].d, 1'b0);
         body(vecs[v].n, vecs[v].f, 1'b0);
         done_cyc(vecs[v].n);
         idle_after(vecs[v].n, 3);
      end
      strobe(8'hA5, 1'b0);
      body("busytrig", 10'b1_1010_0101_0, 1'b1);
      done_cyc("busytrig");
      idle_after("busytrig", 45);
      strobe(8'h81, 1'b1);
      bus.data_i = 8'h81;
      body("b2b1", 10'b1_1000_0001_0, 1'b0);
      done_cyc("b2b1");
      tick();
      bus.trig = 1'b0;
      bus.data_i = 8'h00;
      body("b2b2", 10'b1_1000_0001_0, 1'b0);
      done_cyc("b2b2");
      idle_after("b2b2", 3);
      strobe(8'hA5, 1'b0);
      for (int c = 0; c < 17; c++) tick();
      chk("mid pre state", 32'(present_state), 2);
      chk("mid pre ind", 32'(data_ind), 3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid tx", 32'(tx), 1);
      chk("mid busy", 32'(bus.busy), 0);
      chk("mid state", 32'(present_state), 0);
      chk("mid ind", 32'(data_ind), 0);
      chk("mid done", 32'(bus.done), 0);
      idle_after("midrst", 45);
      strobe(8'h5A, 1'b0);
      body("5A", 10'b1_0101_1010_0, 1'b0);
      done_cyc("5A");
      idle_after("5A", 3);
      rst = 1'b1;
      bus.trig = 1'b1;
      bus.data_i = 8'hFF;
      tick();
      rst = 1'b0;
      bus.trig = 1'b0;
      chk("prio tx", 32'(tx), 1);
      chk("prio busy", 32'(bus.busy), 0);
      chk("prio state", 32'(present_state), 0);
      idle_after("prio", 10);
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
